// File: rtl/counter_session_arbiter.sv
// Session arbiter/controller for the shared counter datapath (counter A, JK flags E and F).
// Grants the datapath to one requester at a time and sequences clear/count/flag for its session.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of
// round-robin.
module counter_session_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset_b,
   input  logic [N_REQ-1:0] req,
   input  logic [WIDTH-1:0] A,
   output logic [N_REQ-1:0] gnt,
   output logic [N_REQ-1:0] done,
   output logic             busy,
   output logic             clr_A_F,
   output logic             incr_A,
   output logic             set_E,
   output logic             clr_E,
   output logic             set_F
);

   localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StClear, StCount, StFlag} state_e;

   state_e            state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [PtrW-1:0]   ptr_q, ptr_d;
   logic              win_vld;
   logic [PtrW-1:0]   win_idx;

   // Low bits of A do not take part in control decoding.
   logic unused_a_low;
   assign unused_a_low = ^A[WIDTH-3:0];

   // Pick the winning requester among the current req bits.
   always_comb begin
      int unsigned idx;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
         idx = k;
`else
         idx = (32'(ptr_q) + k) % N_REQ;
`endif
         if (!win_vld && req[PtrW'(idx)]) begin
            win_vld = 1'b1;
            win_idx = PtrW'(idx);
         end
      end
   end

   // Next state, grant/pointer update and datapath control decode.
   always_comb begin
      int unsigned nxt;
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      done    = '0;
      clr_A_F = 1'b0;
      incr_A  = 1'b0;
      set_E   = 1'b0;
      clr_E   = 1'b0;
      set_F   = 1'b0;
      nxt     = (32'(win_idx) + 1) % N_REQ;
      unique case (state_q)
         StIdle: begin
            if (win_vld) begin
               state_d          = StClear;
               gnt_d            = '0;
               gnt_d[win_idx]   = 1'b1;
`ifndef ARB_FIXED_PRIORITY_EN
               ptr_d            = PtrW'(nxt);
`endif
            end
         end
         StClear: begin
            clr_A_F = 1'b1;
            state_d = StCount;
         end
         StCount: begin
            incr_A = 1'b1;
            set_E  = A[WIDTH-2];
            clr_E  = ~A[WIDTH-2];
            // Terminal pattern 11xx: the final increment happens on this same cycle.
            if (A[WIDTH-1] & A[WIDTH-2]) state_d = StFlag;
         end
         StFlag: begin
            set_F   = 1'b1;
            done    = gnt_q;
            state_d = StIdle;
            gnt_d   = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt  = gnt_q;
   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_counter_session_arbiter.sv
// Bench for counter_session_arbiter: models the counter datapath, keeps a queue of expected
// session owners, and checks grants, done pulses and per-session control timing.
module tb_counter_session_arbiter;

   localparam int unsigned NReq   = 2;
   localparam int unsigned Width  = 4;
   localparam int          NIncr  = 3 * (1 << (Width - 2)) + 1;

   logic              clock = 1'b0;
   logic              reset_b;
   logic [NReq-1:0]   req;
   logic [Width-1:0]  A = '0;
   logic              E = 1'b0;
   logic              F = 1'b0;
   logic [NReq-1:0]   gnt, done;
   logic              busy, clr_A_F, incr_A, set_E, clr_E, set_F;

   int checks = 0;
   int errors = 0;

   logic [NReq-1:0] exp_q[$];

   // Monitor state.
   logic [NReq-1:0] prev_gnt;
   int  clr_cnt, incr_cnt, idle_cnt, grant_cnt = 0;
   bit  after_done, post_done;

   always #5 clock = ~clock;

   counter_session_arbiter #(.N_REQ(NReq), .WIDTH(Width)) dut (
      .clock   (clock),
      .reset_b (reset_b),
      .req     (req),
      .A       (A),
      .gnt     (gnt),
      .done    (done),
      .busy    (busy),
      .clr_A_F (clr_A_F),
      .incr_A  (incr_A),
      .set_E   (set_E),
      .clr_E   (clr_E),
      .set_F   (set_F)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Datapath model: counter A with sync clear, JK flags E and F.
   always @(posedge clock) begin
      if (clr_A_F) begin
         A <= '0;
         F <= 1'b0;
      end else if (incr_A) begin
         A <= A + 1'b1;
      end
      if (set_E) E <= 1'b1;
      else if (clr_E) E <= 1'b0;
      if (set_F) F <= 1'b1;
   end

   // Scoreboard/monitor, sampled mid-cycle.
   always @(negedge clock) begin
      if (!reset_b) begin
         prev_gnt   = '0;
         clr_cnt    = 0;
         incr_cnt   = 0;
         idle_cnt   = 0;
         after_done = 1'b0;
         post_done  = 1'b0;
      end else begin
         check_eq("gnt_onehot0", 32'($onehot0(gnt)), 1);
         check_eq("done_onehot0", 32'($onehot0(done)), 1);
         check_eq("e_exclusive", 32'(set_E & clr_E), 0);
         if (post_done) begin
            check_eq("final_A", 32'(A), 32'hD);
            check_eq("final_E", 32'(E), 1);
            check_eq("final_F", 32'(F), 1);
            check_eq("busy_after", 32'(busy), 0);
            post_done = 1'b0;
         end
         if (!busy) idle_cnt++;
         if (gnt != '0 && prev_gnt == '0) begin
            grant_cnt++;
            if (exp_q.size() == 0) check_eq("gnt_unexpected", 32'(gnt), 0);
            else check_eq("gnt_order", 32'(gnt), 32'(exp_q[0]));
            check_eq("clr_at_grant", 32'(clr_A_F), 1);
            if (after_done) check_eq("idle_gap", idle_cnt, 1);
            clr_cnt  = 0;
            incr_cnt = 0;
         end
         if (clr_A_F) clr_cnt++;
         if (incr_A) incr_cnt++;
         if (done != '0) begin
            if (exp_q.size() == 0) check_eq("done_unexpected", 32'(done), 0);
            else check_eq("done_owner", 32'(done), 32'(exp_q.pop_front()));
            check_eq("done_eq_gnt", 32'(done), 32'(gnt));
            check_eq("clr_cycles", clr_cnt, 1);
            check_eq("incr_cycles", incr_cnt, NIncr);
            check_eq("set_F_at_done", 32'(set_F), 1);
            after_done = 1'b1;
            post_done  = 1'b1;
            idle_cnt   = 0;
         end
         prev_gnt = gnt;
      end
   end

   task automatic do_reset();
      reset_b = 1'b0;
      req     = '0;
      exp_q.delete();
      #1;
      check_eq("reset_outputs",
               32'({gnt, done, busy, clr_A_F, incr_A, set_E, clr_E, set_F}), 0);
      repeat (2) @(negedge clock);
      #2 reset_b = 1'b1;
      @(negedge clock);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0 && !busy && !post_done) return;
         @(negedge clock);
         #1;
      end
      check_eq(tag, 32'(busy) + 32'(exp_q.size()) + 32'(post_done), 0);
   endtask

   task automatic wait_grants(input string tag, input int target);
      for (int i = 0; i < 100; i++) begin
         if (grant_cnt >= target) return;
         @(negedge clock);
         #1;
      end
      check_eq(tag, grant_cnt, target);
   endtask

   initial begin
      int n0;
      bit hit;
      reset_b = 1'b0;
      req     = '0;

      // 1: single session for requester 0.
      do_reset();
      req = 2'b01;
      exp_q.push_back(2'b01);
      @(negedge clock);
      #1;
      check_eq("t1_gnt_next_edge", 32'(gnt), 32'h1);
      req = '0;
      wait_idle("t1_timeout");

      // 2/3: both requesting continuously.
      do_reset();
`ifdef ARB_FIXED_PRIORITY_EN
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b01);
`else
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b01);
`endif
      n0  = grant_cnt;
      req = 2'b11;
      wait_grants("t2_grant_timeout", n0 + 3);
      req = '0;
      wait_idle("t2_timeout");

      // 4: reset during counting, then restart for requester 1.
      do_reset();
      req = 2'b01;
      exp_q.push_back(2'b01);
      @(negedge clock);
      #1;
      req = '0;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clock);
         #1;
         if (incr_A && A == 4'b0101) hit = 1'b1;
      end
      check_eq("t4_reached_A5", 32'(hit), 1);
      reset_b = 1'b0;
      #1;
      check_eq("t4_gnt_async", 32'(gnt), 0);
      check_eq("t4_incr_async", 32'(incr_A), 0);
      check_eq("t4_busy_async", 32'(busy), 0);
      exp_q.delete();
      @(negedge clock);
      #1;
      reset_b = 1'b1;
      req     = 2'b10;
      exp_q.push_back(2'b10);
      @(negedge clock);
      #1;
      check_eq("t4_gnt_restart", 32'(gnt), 32'h2);
      check_eq("t4_clear_restart", 32'(clr_A_F), 1);
      req = '0;
      wait_idle("t4_timeout");

      // 5: owner drops req on its third count cycle.
      do_reset();
      req = 2'b01;
      exp_q.push_back(2'b01);
      n0 = 0;
      for (int i = 0; i < 20 && n0 < 3; i++) begin
         @(negedge clock);
         #1;
         if (incr_A) n0++;
      end
      req = '0;
      wait_idle("t5_timeout");

      // 6: requester 1 arrives mid-session of requester 0.
      do_reset();
      req = 2'b01;
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b10);
      n0 = grant_cnt;
      @(negedge clock);
      #1;
      req = '0;
      repeat (4) @(negedge clock);
      #1;
      req = 2'b10;
      wait_grants("t6_grant_timeout", n0 + 2);
      req = '0;
      wait_idle("t6_timeout");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
